// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter and the load/store units that feed it.
package dmem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic REQ_LD = 1'b0;
    localparam logic REQ_ST = 1'b1;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    function automatic logic is_misaligned(input logic [1:0] i_lsb);
        return i_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin arbiter: combinational grant, last_winner updated on i_update.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_update,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_last;

    // Requester 0 wins when alone, or when contested and requester 1 won last time.
    assign o_gnt0 = i_req0 & (~i_req1 | (r_last == REQ_ST));
    assign o_gnt1 = i_req1 & ~o_gnt0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_ST;
        end else if (i_update) begin
            r_last <= o_gnt1 ? REQ_ST : REQ_LD;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Load/store arbiter and sequencer for the single data-memory port.
// Optional misaligned-access trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_valid,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              st_done,
    output logic              acc_err,
    output logic              dmem_re,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              busy
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_winner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_re;
    logic              r_we;

    logic              w_gnt_ld;
    logic              w_gnt_st;
    logic              w_win;
    logic              w_win_id;
    logic              w_update;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_misalign;

    assign w_win      = w_gnt_ld | w_gnt_st;
    assign w_win_id   = w_gnt_st ? REQ_ST : REQ_LD;
    assign w_update   = (r_state == ST_IDLE) & w_win;
    assign w_win_addr = w_gnt_st ? st_addr : ld_addr;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_req0   (ld_req),
        .i_req1   (st_req),
        .i_update (w_update),
        .o_gnt0   (w_gnt_ld),
        .o_gnt1   (w_gnt_st)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_err;

    assign w_misalign = is_misaligned(w_win_addr[1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_update) begin
            r_err <= w_misalign;
        end
    end

    assign acc_err = (r_state == ST_DONE) & r_err;
`else
    assign w_misalign = 1'b0;
    assign acc_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_winner <= REQ_LD;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_re     <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win) begin
                        r_winner <= w_win_id;
                        r_addr   <= w_win_addr;
                        r_cnt    <= '0;
                        if (w_gnt_st) begin
                            r_wdata <= st_wdata;
                        end
                        // A trapped access never touches memory and returns zero data.
                        if (w_misalign) begin
                            r_rdata <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_re    <= (w_win_id == REQ_LD);
                            r_we    <= (w_win_id == REQ_ST);
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAST_CNT) begin
                        if (r_re) begin
                            r_rdata <= dmem_rdata;
                        end
                        r_re    <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dmem_re    = r_re;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign ld_rdata   = r_rdata;
    assign ld_valid   = (r_state == ST_DONE) & (r_winner == REQ_LD);
    assign st_done    = (r_state == ST_DONE) & (r_winner == REQ_ST);
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: instance A runs MEM_LATENCY=1, instance B runs MEM_LATENCY=3.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset_n;
    int unsigned checks;
    int unsigned failures;

    logic        ld_req_a, st_req_a, ld_valid_a, st_done_a, acc_err_a, dmem_re_a, dmem_we_a, busy_a;
    logic [31:0] ld_addr_a, st_addr_a, st_wdata_a, ld_rdata_a, dmem_addr_a, dmem_wdata_a, dmem_rdata_a;
    logic        ld_req_b, st_req_b, ld_valid_b, st_done_b, acc_err_b, dmem_re_b, dmem_we_b, busy_b;
    logic [31:0] ld_addr_b, st_addr_b, st_wdata_b, ld_rdata_b, dmem_addr_b, dmem_wdata_b, dmem_rdata_b;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .ld_req(ld_req_a), .ld_addr(ld_addr_a), .ld_rdata(ld_rdata_a), .ld_valid(ld_valid_a),
        .st_req(st_req_a), .st_addr(st_addr_a), .st_wdata(st_wdata_a), .st_done(st_done_a),
        .acc_err(acc_err_a), .dmem_re(dmem_re_a), .dmem_we(dmem_we_a), .dmem_addr(dmem_addr_a),
        .dmem_wdata(dmem_wdata_a), .dmem_rdata(dmem_rdata_a), .busy(busy_a)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .ld_req(ld_req_b), .ld_addr(ld_addr_b), .ld_rdata(ld_rdata_b), .ld_valid(ld_valid_b),
        .st_req(st_req_b), .st_addr(st_addr_b), .st_wdata(st_wdata_b), .st_done(st_done_b),
        .acc_err(acc_err_b), .dmem_re(dmem_re_b), .dmem_we(dmem_we_b), .dmem_addr(dmem_addr_b),
        .dmem_wdata(dmem_wdata_b), .dmem_rdata(dmem_rdata_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({ld_valid_a, st_done_a, acc_err_a, dmem_re_a, dmem_we_a, busy_a} !== 6'b0) begin failures++; $display("FAIL reset_ctrl_a got=%b exp=000000", {ld_valid_a, st_done_a, acc_err_a, dmem_re_a, dmem_we_a, busy_a}); end
        checks++; if ({ld_valid_b, st_done_b, acc_err_b, dmem_re_b, dmem_we_b, busy_b} !== 6'b0) begin failures++; $display("FAIL reset_ctrl_b got=%b exp=000000", {ld_valid_b, st_done_b, acc_err_b, dmem_re_b, dmem_we_b, busy_b}); end
        checks++; if ({dmem_addr_a, dmem_wdata_a, ld_rdata_a} !== 96'h0) begin failures++; $display("FAIL reset_data_a got=%h exp=0", {dmem_addr_a, dmem_wdata_a, ld_rdata_a}); end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic odd;
        ld_req_a = 1'b1; ld_addr_a = 32'h40;
        st_req_a = 1'b1; st_addr_a = 32'h44; st_wdata_a = 32'h0BADCAFE;
        for (int k = 0; k < 4; k++) begin
            odd = 1'(k % 2);
            step();
            checks++; if ({dmem_re_a, dmem_we_a} !== {~odd, odd}) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, {dmem_re_a, dmem_we_a}, {~odd, odd}); end
            checks++; if (dmem_addr_a !== (odd ? 32'h44 : 32'h40)) begin failures++; $display("FAIL rr_addr%0d got=%h exp=%h", k, dmem_addr_a, odd ? 32'h44 : 32'h40); end
            step();
            checks++; if ({ld_valid_a, st_done_a} !== {~odd, odd}) begin failures++; $display("FAIL rr_done%0d got=%b exp=%b", k, {ld_valid_a, st_done_a}, {~odd, odd}); end
            step();
            checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rr_idle%0d got=%b exp=0", k, busy_a); end
        end
        ld_req_a = 1'b0; st_req_a = 1'b0;
        step();
        step();
    endtask

    task automatic test_load_lat1();
        ld_req_a = 1'b1; ld_addr_a = 32'h10;
        step();
        checks++; if ({dmem_re_a, dmem_we_a, busy_a, ld_valid_a} !== 4'b1010) begin failures++; $display("FAIL ld1_c1_ctrl got=%b exp=1010", {dmem_re_a, dmem_we_a, busy_a, ld_valid_a}); end
        checks++; if (dmem_addr_a !== 32'h10) begin failures++; $display("FAIL ld1_c1_addr got=%h exp=00000010", dmem_addr_a); end
        step();
        checks++; if ({dmem_re_a, dmem_we_a, busy_a, ld_valid_a, acc_err_a} !== 5'b00110) begin failures++; $display("FAIL ld1_c2_ctrl got=%b exp=00110", {dmem_re_a, dmem_we_a, busy_a, ld_valid_a, acc_err_a}); end
        checks++; if (ld_rdata_a !== 32'hDEADBEEF) begin failures++; $display("FAIL ld1_rdata got=%h exp=deadbeef", ld_rdata_a); end
        ld_req_a = 1'b0;
        step();
        checks++; if ({busy_a, ld_valid_a, dmem_we_a} !== 3'b000) begin failures++; $display("FAIL ld1_c3 got=%b exp=000", {busy_a, ld_valid_a, dmem_we_a}); end
    endtask

    task automatic test_store_lat3();
        st_req_b = 1'b1; st_addr_b = 32'h20; st_wdata_b = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++; if ({dmem_we_b, dmem_re_b, busy_b, st_done_b} !== 4'b1010) begin failures++; $display("FAIL st3_c%0d_ctrl got=%b exp=1010", c, {dmem_we_b, dmem_re_b, busy_b, st_done_b}); end
            checks++; if ({dmem_addr_b, dmem_wdata_b} !== {32'h20, 32'h12345678}) begin failures++; $display("FAIL st3_c%0d_bus got=%h exp=0000002012345678", c, {dmem_addr_b, dmem_wdata_b}); end
            if (c == 1) st_wdata_b = 32'hFFFFFFFF;
        end
        step();
        checks++; if ({st_done_b, dmem_we_b, busy_b} !== 3'b101) begin failures++; $display("FAIL st3_c4 got=%b exp=101", {st_done_b, dmem_we_b, busy_b}); end
        st_req_b = 1'b0;
        step();
        checks++; if ({st_done_b, busy_b} !== 2'b00) begin failures++; $display("FAIL st3_c5 got=%b exp=00", {st_done_b, busy_b}); end
    endtask

    task automatic test_latch_hold();
        ld_req_b = 1'b1; ld_addr_b = 32'h10; dmem_rdata_b = 32'h11111111;
        step();
        ld_req_b = 1'b0; ld_addr_b = 32'h99;
        for (int c = 1; c <= 3; c++) begin
            checks++; if ({dmem_re_b, dmem_addr_b} !== {1'b1, 32'h10}) begin failures++; $display("FAIL hold_c%0d got=%h exp=100000010", c, {dmem_re_b, dmem_addr_b}); end
            if (c == 3) dmem_rdata_b = 32'hCAFEF00D;
            step();
        end
        checks++; if ({ld_valid_b, dmem_re_b} !== 2'b10) begin failures++; $display("FAIL hold_valid got=%b exp=10", {ld_valid_b, dmem_re_b}); end
        checks++; if (ld_rdata_b !== 32'hCAFEF00D) begin failures++; $display("FAIL hold_rdata got=%h exp=cafef00d", ld_rdata_b); end
        step();
        checks++; if ({ld_valid_b, busy_b} !== 2'b00) begin failures++; $display("FAIL hold_idle got=%b exp=00", {ld_valid_b, busy_b}); end
    endtask

    task automatic test_align();
        ld_req_a = 1'b1; ld_addr_a = 32'h13;
        step();
`ifdef DMEM_ALIGN_CHECK_EN
        checks++; if ({ld_valid_a, acc_err_a, dmem_re_a, dmem_we_a} !== 4'b1100) begin failures++; $display("FAIL align_trap got=%b exp=1100", {ld_valid_a, acc_err_a, dmem_re_a, dmem_we_a}); end
        checks++; if (ld_rdata_a !== 32'h0) begin failures++; $display("FAIL align_rdata got=%h exp=00000000", ld_rdata_a); end
        ld_req_a = 1'b0;
        step();
`else
        checks++; if ({dmem_re_a, acc_err_a, dmem_addr_a} !== {2'b10, 32'h13}) begin failures++; $display("FAIL align_fwd got=%h exp=200000013", {dmem_re_a, acc_err_a, dmem_addr_a}); end
        step();
        checks++; if ({ld_valid_a, acc_err_a} !== 2'b10) begin failures++; $display("FAIL align_done got=%b exp=10", {ld_valid_a, acc_err_a}); end
        checks++; if (ld_rdata_a !== 32'hDEADBEEF) begin failures++; $display("FAIL align_rdata got=%h exp=deadbeef", ld_rdata_a); end
        ld_req_a = 1'b0;
        step();
`endif
        checks++; if ({busy_a, acc_err_a} !== 2'b00) begin failures++; $display("FAIL align_idle got=%b exp=00", {busy_a, acc_err_a}); end
    endtask

    task automatic test_reset_mid_access();
        st_req_b = 1'b1; st_addr_b = 32'h30; st_wdata_b = 32'hA5A5A5A5;
        step();
        step();
        checks++; if (dmem_we_b !== 1'b1) begin failures++; $display("FAIL rst_pre_we got=%b exp=1", dmem_we_b); end
        reset_n = 1'b0;
        #1;
        checks++; if ({dmem_we_b, busy_b, st_done_b} !== 3'b000) begin failures++; $display("FAIL rst_abort got=%b exp=000", {dmem_we_b, busy_b, st_done_b}); end
        st_req_b = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if ({st_done_b, busy_b} !== 2'b00) begin failures++; $display("FAIL rst_nodone%0d got=%b exp=00", c, {st_done_b, busy_b}); end
        end
        ld_req_b = 1'b1; ld_addr_b = 32'h50;
        st_req_b = 1'b1; st_addr_b = 32'h54;
        step();
        checks++; if ({dmem_re_b, dmem_we_b, dmem_addr_b} !== {2'b10, 32'h50}) begin failures++; $display("FAIL rst_first_grant got=%h exp=200000050", {dmem_re_b, dmem_we_b, dmem_addr_b}); end
        ld_req_b = 1'b0; st_req_b = 1'b0;
        step();
        step();
        step();
        checks++; if ({ld_valid_b, st_done_b} !== 2'b10) begin failures++; $display("FAIL rst_ld_done got=%b exp=10", {ld_valid_b, st_done_b}); end
        step();
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL rst_final_idle got=%b exp=0", busy_b); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0;
        ld_req_a = 1'b0; ld_addr_a = '0; st_req_a = 1'b0; st_addr_a = '0; st_wdata_a = '0;
        ld_req_b = 1'b0; ld_addr_b = '0; st_req_b = 1'b0; st_addr_b = '0; st_wdata_b = '0;
        dmem_rdata_a = 32'hDEADBEEF;
        dmem_rdata_b = 32'h0;
        test_reset();
        test_round_robin();
        test_load_lat1();
        test_store_lat3();
        test_latch_hold();
        test_align();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
